// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry layout is the FIFO payload: PC plus raw instruction word.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 21;
  localparam int PC_W    = 64;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries for the fetch stage.
// Flush empties it in one cycle; push and pop may coincide when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= din;
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem requests, decode FIFO.
// Optional FETCH_PERF_EN adds perf_fetched/perf_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int N = PC_W,
  parameter int DEPTH = 2,
  parameter logic [N-1:0] PC_RESET = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [N-1:0] imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  input  logic         branch_valid,
  input  logic [N-1:0] branch_target,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [31:0]  dec_instr,
  output logic [10:0]  dec_op,
  output logic [N-1:0] dec_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [N-1:0]  pc_q, pc_d;
  logic [N-1:0]  req_pc_q, req_pc_d;
  logic          out_q, out_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_entry_t  head, din;
  logic          rsp_acc, push, dec_fire, req_fire;

  assign rsp_acc  = imem_rsp_valid & out_q;
  assign dec_valid = (count != '0) & ~branch_valid;
  assign dec_fire = dec_valid & dec_ready;

  // Slots committed after this cycle: buffered + in flight - leaving
  assign occ = {1'b0, count} + (CW+1)'(out_q)
             - (CW+1)'(dec_fire);

  assign imem_req_valid = ~reset & ~branch_valid
                        & (~out_q | imem_rsp_valid)
                        & (occ < (CW+1)'(DEPTH));
  assign imem_req_addr = pc_q;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign push = rsp_acc & ~drop_q & ~branch_valid;

  always_comb begin
    din       = '0;
    din.pc    = PC_W'(req_pc_q);
    din.instr = imem_rsp_data;
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_d    = out_q;
    drop_d   = drop_q;
    if (req_fire) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + N'(4);
      out_d    = 1'b1;
    end else if (rsp_acc) begin
      out_d = 1'b0;
    end
    if (rsp_acc) begin
      drop_d = 1'b0;
    end else if (branch_valid && out_q) begin
      drop_d = 1'b1;
    end
    if (branch_valid) pc_d = branch_target & ~N'(3);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= PC_RESET;
      req_pc_q <= '0;
      out_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (din),
    .pop   (dec_fire),
    .flush (branch_valid),
    .count (count),
    .head  (head)
  );

  assign dec_instr = head.instr;
  assign dec_op    = head.instr[OP_MSB:OP_LSB];
  assign dec_pc    = N'(head.pc);

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, flushed_q;
  logic [31:0] flush_inc;

  assign flush_inc = (branch_valid ? 32'(count) : 32'd0)
                   + 32'(rsp_acc & (drop_q | branch_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(dec_fire);
      flushed_q <= flushed_q + flush_inc;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable imem model.
// Perf counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        branch_valid;
  logic [63:0] branch_target;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [10:0] dec_op;
  logic [63:0] dec_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  int total = 0;
  int bad = 0;

  int          lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;
  int          acc_cnt = 0;
  int          fire_cnt = 0;
  int          proto_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.N(64), .DEPTH(2), .PC_RESET(64'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .branch_valid   (branch_valid),
    .branch_target  (branch_target),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_op         (dec_op),
    .dec_pc         (dec_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  function automatic logic [31:0] mdl(input logic [63:0] a);
    return 32'hC3A5_0000 ^ {a[15:0], ~a[15:0]};
  endfunction

  assign imem_rsp_valid = mem_pend && (mem_cnt == 1);
  assign imem_rsp_data  = mdl(mem_addr);

  // Memory model: one request in flight, response lat cycles after accept
  always @(posedge clk) begin
    if (reset) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 0;
      acc_cnt  <= 0;
      fire_cnt <= 0;
    end else begin
      if (dec_valid && dec_ready) fire_cnt <= fire_cnt + 1;
      if (mem_pend) begin
        if (mem_cnt == 1) mem_pend <= 1'b0;
        else mem_cnt <= mem_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        if (mem_pend && mem_cnt != 1) proto_err <= proto_err + 1;
        mem_pend <= 1'b1;
        mem_cnt  <= lat;
        mem_addr <= imem_req_addr;
        acc_cnt  <= acc_cnt + 1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    branch_valid = 1'b0;
    branch_target = '0;
    dec_ready = 1'b1;
    imem_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    lat = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      total++;
      if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_outs: dec_valid=%b req_valid=%b want 0 0",
                 dec_valid, imem_req_valid);
      end
    end
    reset = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
      bad++;
      $display("FAIL reset_first_req: valid=%b addr=%h want 1 0",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [63:0] exp;
    logic [31:0] w;
    lat = 1;
    do_reset();
    @(negedge clk); #1;
    total++;
    if (dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_latency: dec_valid=%b want 0", dec_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      exp = 64'(4 * i);
      w = mdl(exp);
      total++;
      if (dec_valid !== 1'b1 || dec_pc !== exp || dec_instr !== w
          || dec_op !== w[31:21]) begin
        bad++;
        $display("FAIL stream_%0d: v=%b pc=%h ins=%h op=%h want 1 %h %h %h",
                 i, dec_valid, dec_pc, dec_instr, dec_op, exp, w, w[31:21]);
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp;
    int n;
    lat = 1;
    do_reset();
    dec_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (dec_valid) begin
        total++;
        if (dec_pc !== 64'h0 || dec_instr !== mdl(64'h0)) begin
          bad++;
          $display("FAIL stall_head: pc=%h ins=%h want 0 %h",
                   dec_pc, dec_instr, mdl(64'h0));
        end
      end
    end
    total++;
    if (acc_cnt !== 2 || imem_req_valid !== 1'b0 || dec_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_full: acc=%0d req=%b dv=%b want 2 0 1",
               acc_cnt, imem_req_valid, dec_valid);
    end
    dec_ready = 1'b1;
    #1;
    n = 0;
    exp = '0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      if (dec_valid) begin
        total++;
        if (dec_pc !== exp) begin
          bad++;
          $display("FAIL stall_seq: pc=%h want %h", dec_pc, exp);
        end
        exp += 64'd4;
        n++;
      end
      @(negedge clk); #1;
    end
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL stall_timeout: fires=%0d want 6", n);
    end
  endtask

  task automatic test_branch_inflight();
    logic seen;
    lat = 3;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      if (mem_pend && mem_addr == 64'h8 && mem_cnt != 1) break;
      @(negedge clk); #1;
    end
    total++;
    if (!(mem_pend && mem_addr == 64'h8)) begin
      bad++;
      $display("FAIL br_wait: pend=%b addr=%h want 1 8", mem_pend, mem_addr);
    end
    branch_valid = 1'b1;
    branch_target = 64'h100;
    #1;
    total++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL br_block: dv=%b req=%b want 0 0", dec_valid, imem_req_valid);
    end
    @(negedge clk);
    branch_valid = 1'b0;
    #1;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (imem_req_valid && !seen) begin
        seen = 1'b1;
        total++;
        if (imem_req_addr !== 64'h100) begin
          bad++;
          $display("FAIL br_req: addr=%h want 100", imem_req_addr);
        end
      end
      if (dec_valid) break;
      @(negedge clk); #1;
    end
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h100 || dec_instr !== mdl(64'h100)) begin
      bad++;
      $display("FAIL br_target: dv=%b pc=%h ins=%h want 1 100 %h",
               dec_valid, dec_pc, dec_instr, mdl(64'h100));
    end
  endtask

  task automatic test_branch_same_rsp();
    lat = 3;
    do_reset();
    for (int c = 0; c < 30; c++) begin
      if (imem_rsp_valid) break;
      @(negedge clk); #1;
    end
    branch_valid = 1'b1;
    branch_target = 64'h103;
    #1;
    total++;
    if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle: rsp=%b req=%b want 1 0",
               imem_rsp_valid, imem_req_valid);
    end
    @(negedge clk);
    branch_valid = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) begin
      bad++;
      $display("FAIL same_req: v=%b addr=%h want 1 100",
               imem_req_valid, imem_req_addr);
    end
    for (int c = 0; c < 30; c++) begin
      if (dec_valid) break;
      @(negedge clk); #1;
    end
    total++;
    if (dec_valid !== 1'b1 || dec_pc !== 64'h100) begin
      bad++;
      $display("FAIL same_nodrop: dv=%b pc=%h want 1 100", dec_valid, dec_pc);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp;
    int n;
    lat = 1;
    do_reset();
    branch_valid = 1'b1;
    branch_target = '1;
    #1;
    @(negedge clk);
    branch_valid = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_req: v=%b addr=%h want 1 fffffffffffffffc",
               imem_req_valid, imem_req_addr);
    end
    exp = 64'hFFFF_FFFF_FFFF_FFFC;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (dec_valid) begin
        total++;
        if (dec_pc !== exp) begin
          bad++;
          $display("FAIL wrap_seq: pc=%h want %h", dec_pc, exp);
        end
        exp += 64'd4;
        n++;
      end
      @(negedge clk); #1;
    end
    total++;
    if (n !== 3) begin
      bad++;
      $display("FAIL wrap_timeout: fires=%0d want 3", n);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    lat = 1;
    do_reset();
    dec_ready = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    total++;
    if (perf_flushed !== 32'd0 || perf_fetched !== 32'd0) begin
      bad++;
      $display("FAIL perf_idle: fl=%0d fe=%0d want 0 0", perf_flushed, perf_fetched);
    end
    lat = 3;
    branch_valid = 1'b1;
    branch_target = 64'h100;
    @(negedge clk);
    branch_valid = 1'b0;
    dec_ready = 1'b1;
    #1;
    total++;
    if (perf_flushed !== 32'd2) begin
      bad++;
      $display("FAIL perf_flush2: fl=%0d want 2", perf_flushed);
    end
    for (int c = 0; c < 40; c++) begin
      if (mem_pend && mem_addr == 64'h104 && mem_cnt == 2) break;
      @(negedge clk); #1;
    end
    total++;
    if (perf_fetched !== 32'd1 || dec_valid !== 1'b0) begin
      bad++;
      $display("FAIL perf_fetch1: fe=%0d dv=%b want 1 0", perf_fetched, dec_valid);
    end
    branch_valid = 1'b1;
    branch_target = 64'h200;
    @(negedge clk);
    branch_valid = 1'b0;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (dec_valid) break;
      @(negedge clk); #1;
    end
    total++;
    if (dec_pc !== 64'h200 || perf_flushed !== 32'd3) begin
      bad++;
      $display("FAIL perf_flush3: pc=%h fl=%0d want 200 3", dec_pc, perf_flushed);
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (perf_fetched !== 32'(fire_cnt)) begin
      bad++;
      $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, fire_cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    branch_valid = 1'b0;
    branch_target = '0;
    dec_ready = 1'b1;
    imem_req_ready = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_branch_inflight();
    test_branch_same_rsp();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    total++;
    if (proto_err !== 0) begin
      bad++;
      $display("FAIL one_outstanding: violations=%0d want 0", proto_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
